matmul_sequencer: RTL

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_pkg.sv | 7 +
 rtl/seq_counter.sv | 20 ++
 rtl/matmul_sequencer.sv | 90 +++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared FSM state type and default timing constants for matmul_sequencer
package matmul_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} seq_state_t;
  localparam int CLR_CYCLES_DEF = 2;
  localparam int TIMEOUT_DEF = 1023;
  localparam int CNT_W = 16;
endpackage

// File: rtl/seq_counter.sv
// seq_counter: loadable saturating up/down counter with a compare-to-terminal flag
module seq_counter
  import matmul_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] term_val,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en) cnt <= up ? (&cnt ? cnt : cnt + 1'b1) : (cnt == '0 ? cnt : cnt - 1'b1);
  assign term = cnt == term_val;
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: one-job-at-a-time sequencer around an external matrix multiplier.
// Define MATMUL_SEQ_TIMEOUT_EN to end RUN after TIMEOUT cycles with rsp_err set.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DIM        = 16,
  parameter int WIDTH      = 4,
  parameter int CLR_CYCLES = CLR_CYCLES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [DIM*DIM*WIDTH-1:0]     req_a,
  input  logic [DIM*DIM*WIDTH-1:0]     req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DIM*DIM*2*WIDTH-1:0]   rsp_c,
  output logic                         rsp_err,
  output logic                         mul_rst_n,
  output logic [DIM*DIM*WIDTH-1:0]     mul_in0,
  output logic [DIM*DIM*WIDTH-1:0]     mul_in1,
  input  logic [DIM*DIM*2*WIDTH-1:0]   mul_out,
  input  logic                         mul_finished,
  output logic                         busy
);
  seq_state_t state;
  logic mul_rst_q, hs, fin, tmo, term;
  logic [CNT_W-1:0] cnt;
  assign hs = req_valid & req_ready;
  // RUN cycle 1 has cnt == 1; a finished flag left over from before release is ignored there
  assign fin = mul_finished & (cnt != CNT_W'(1));
  assign busy = state != IDLE;
  assign mul_rst_n = reset_n & mul_rst_q;
`ifdef MATMUL_SEQ_TIMEOUT_EN
  assign tmo = term;
`else
  assign tmo = 1'b0;
`endif
  seq_counter u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (hs || (state == CLEAR && term)),
    .en       (state == CLEAR || state == RUN),
    .up       (state == RUN),
    .load_val (state == IDLE ? CNT_W'(CLR_CYCLES) : CNT_W'(1)),
    .term_val (state == RUN ? CNT_W'(TIMEOUT) : CNT_W'(1)),
    .cnt      (cnt),
    .term     (term)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_c     <= '0;
      mul_in0   <= '0;
      mul_in1   <= '0;
      mul_rst_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= !hs;
          if (hs) begin
            mul_in0   <= req_a;
            mul_in1   <= req_b;
            mul_rst_q <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR: if (term) begin
          mul_rst_q <= 1'b1;
          state     <= RUN;
        end
        RUN: if (fin || tmo) begin
          rsp_c     <= mul_out;
          rsp_err   <= !fin;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
endmodule
